// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: memory request/response channel, decoder-facing instruction
// stream, redirect input and queue occupancy.
//
// Modports
//   master : fetch unit side (drives mem_req/mem_addr, instr_*, count)
//   slave  : environment side (memory, decoder, branch unit)
//
// Parameters
//   IW : instruction width in bits
//   AW : instruction address width in bits
//   CW : occupancy counter width, $clog2(DEPTH)+1 of the attached fetch unit
interface fetch_unit_if #(
  parameter int unsigned IW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned CW = 3
);
  // Memory request / response
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [IW-1:0] mem_rdata;
  // Instruction stream to decoder
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_addr;
  logic          instr_ready;
  // Control flow change
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  // Queue occupancy
  logic [CW-1:0] count;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output instr_valid, instr, instr_addr,
    input  instr_ready,
    input  redirect, redirect_addr,
    output count
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  instr_valid, instr, instr_addr,
    output instr_ready,
    output redirect, redirect_addr,
    input  count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit with a prefetch queue.
//
// Issues one memory read at a time starting at RESET_ADDR, stepping by STEP, and
// queues {data, address} pairs for the decoder. A queue slot is reserved when a
// request is issued, so a response can always be pushed. A redirect flushes the
// queue, discards any in-flight response and restarts fetching at redirect_addr.
//
// Ports
//   clk          : clock, all state on rising edge
//   reset        : asynchronous, active-high reset
//   bus          : fetch_unit_if.master (memory channel, instruction stream,
//                  redirect, queue occupancy)
//   stall_cycles : (only with FETCH_UNIT_STALL_COUNT_EN) saturating count of cycles
//                  where the decoder was ready but no instruction was valid
//
// Optional feature macro: FETCH_UNIT_STALL_COUNT_EN
module fetch_unit #(
  parameter int unsigned    IW         = 32,
  parameter int unsigned    AW         = 32,
  parameter int unsigned    DEPTH      = 4,
  parameter int unsigned    STEP       = 1,
  parameter logic [AW-1:0]  RESET_ADDR = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
`ifdef FETCH_UNIT_STALL_COUNT_EN
  ,
  output logic [15:0]  stall_cycles
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrop
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;             // next address to fetch
  logic [AW-1:0] req_addr_q, req_addr_d; // address of the request being issued
  logic          flush_q, flush_d;       // redirect seen while REQ waits for its grant
  logic          armed_q;                // one cycle of settling after reset release

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] data_mem [DEPTH];
  logic [AW-1:0] addr_mem [DEPTH];

  logic          push;
  logic          pop;
  logic          valid;

  assign valid = (count_q != '0);
  // A pop coinciding with a redirect is discarded along with the rest of the queue.
  assign pop   = valid && bus.instr_ready && !bus.redirect;

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    flush_d    = flush_q;
    push       = 1'b0;

    // A redirect always retargets the fetch pc, whatever the state.
    if (bus.redirect) begin
      pc_d = bus.redirect_addr;
    end

    case (state_q)
      StIdle: begin
        // Nothing is outstanding in IDLE, so occupancy alone decides the reservation.
        if (armed_q && !bus.redirect && (count_q < CW'(DEPTH))) begin
          state_d    = StReq;
          req_addr_d = pc_q;
          flush_d    = 1'b0;
        end
      end
      StReq: begin
        // The request stays on the bus even when redirected; its data is dropped later.
        if (bus.redirect) begin
          flush_d = 1'b1;
        end
        if (bus.mem_gnt) begin
          if (bus.redirect || flush_q) begin
            state_d = StDrop;
          end else begin
            state_d = StWait;
            pc_d    = pc_q + AW'(STEP);
          end
        end
      end
      StWait: begin
        if (bus.mem_rvalid) begin
          state_d = StIdle;
          push    = !bus.redirect;
        end else if (bus.redirect) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (bus.mem_rvalid) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_ADDR;
      req_addr_q <= RESET_ADDR;
      flush_q    <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      flush_q    <= flush_d;
      armed_q    <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch queue
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.mem_rdata;
      addr_mem[wr_ptr_q] <= req_addr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.mem_req     = (state_q == StReq);
  assign bus.mem_addr    = req_addr_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? data_mem[rd_ptr_q] : '0;
  assign bus.instr_addr  = valid ? addr_mem[rd_ptr_q] : '0;
  assign bus.count       = count_q;

`ifdef FETCH_UNIT_STALL_COUNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (bus.instr_ready && !valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
module tb_fetch_unit;

  localparam int unsigned IW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned STEP  = 1;
  localparam int unsigned CW    = 3;

  logic clk;
  logic reset;

  fetch_unit_if #(.IW(IW), .AW(AW), .CW(CW)) bus ();
  fetch_unit_if #(.IW(IW), .AW(AW), .CW(CW)) bus_w ();

`ifdef FETCH_UNIT_STALL_COUNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] stall_cycles_w;
`endif

  fetch_unit #(
    .IW(IW), .AW(AW), .DEPTH(DEPTH), .STEP(STEP), .RESET_ADDR(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_UNIT_STALL_COUNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  // Second instance starting at the top of the address space.
  fetch_unit #(
    .IW(IW), .AW(AW), .DEPTH(DEPTH), .STEP(STEP), .RESET_ADDR(32'hFFFF_FFFF)
  ) dut_w (
    .clk(clk),
    .reset(reset),
    .bus(bus_w)
`ifdef FETCH_UNIT_STALL_COUNT_EN
    ,
    .stall_cycles(stall_cycles_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [AW-1:0] exp_pc;     // address of the next instruction the decoder must see
  logic [AW-1:0] fpc_m;      // address the next fresh request must carry
  int            cnt_m;      // expected queue occupancy
  logic          in_req;     // a request is on the bus, not yet granted
  logic [AW-1:0] held;       // its address
  logic          pend;       // granted, response not yet returned
  logic [AW-1:0] pend_addr;
  int            lat;        // idle cycles left before the response
  logic          live;       // response belongs to the current instruction stream
  int            grants;
  int            pops;
  logic [AW-1:0] pop_log[$];

  // Memory knobs
  logic          lat_rand;
  int            lat_fix;
  logic          spur_en;

  function automatic logic [IW-1:0] mdata(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check the current outputs against the model, advance the
  // model by the handshakes that happen at the coming edge, then step past the edge.
  task automatic cycle(input logic gnt, input logic rdy, input logic redir,
                       input logic [AW-1:0] raddr);
    logic rv;
    logic spur;
    logic push;
    logic pop;
    rv   = pend && (lat == 0);
    spur = !pend && spur_en && ($urandom_range(0, 15) == 0);
    bus.mem_rvalid    = rv || spur;
    bus.mem_rdata     = rv ? mdata(pend_addr) : IW'($urandom());
    bus.mem_gnt       = gnt;
    bus.instr_ready   = rdy;
    bus.redirect      = redir;
    bus.redirect_addr = raddr;

    check_eq("count", bus.count, cnt_m);
    check_eq("valid", bus.instr_valid, cnt_m != 0);
    if (in_req) begin
      check_eq("req_held", bus.mem_req, 1'b1);
      check_eq("addr_hold", bus.mem_addr, held);
    end else if (bus.mem_req) begin
      check_eq("one_outstanding", pend, 1'b0);
      check_eq("req_addr", bus.mem_addr, fpc_m);
      in_req = 1'b1;
      live   = 1'b1;
      held   = bus.mem_addr;
    end

    pop = bus.instr_valid && rdy;
    if (pop && !redir) begin
      check_eq("instr_addr", bus.instr_addr, exp_pc);
      check_eq("instr", bus.instr, mdata(exp_pc));
      pop_log.push_back(bus.instr_addr);
      pops++;
      exp_pc = exp_pc + AW'(STEP);
    end

    if (redir && (in_req || pend)) live = 1'b0;

    push = 1'b0;
    if (rv) begin
      push = live;
      pend = 1'b0;
    end

    if (bus.mem_req && gnt) begin
      grants++;
      pend      = 1'b1;
      pend_addr = bus.mem_addr;
      lat       = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
      in_req    = 1'b0;
      if (redir) fpc_m = raddr;
      else if (live) fpc_m = fpc_m + AW'(STEP);
    end else begin
      if (redir) fpc_m = raddr;
      if (pend) lat = lat - 1;
    end

    if (redir) begin
      cnt_m  = 0;
      exp_pc = raddr;
    end else begin
      cnt_m = cnt_m + int'(push) - int'(pop && !redir);
    end

    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    bus.mem_gnt       = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
    bus.instr_ready   = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    bus_w.mem_gnt       = 1'b0;
    bus_w.mem_rvalid    = 1'b0;
    bus_w.mem_rdata     = '0;
    bus_w.instr_ready   = 1'b0;
    bus_w.redirect      = 1'b0;
    bus_w.redirect_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_req", bus.mem_req, 1'b0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_valid", bus.instr_valid, 1'b0);
    check_eq("rst_instr", bus.instr, 32'h0);
    check_eq("rst_instr_addr", bus.instr_addr, 32'h0);
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_w_mem_addr", bus_w.mem_addr, 32'hFFFF_FFFF);
`ifdef FETCH_UNIT_STALL_COUNT_EN
    check_eq("rst_stall", stall_cycles, 16'h0);
`endif
    exp_pc = 32'h0;
    fpc_m  = 32'h0;
    cnt_m  = 0;
    in_req = 1'b0;
    pend   = 1'b0;
    live   = 1'b0;
    lat    = 0;
    grants = 0;
    pops   = 0;
    pop_log.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("first_req_edge1", bus.mem_req, 1'b0);
    @(posedge clk);
    #1;
    check_eq("first_req_edge2", bus.mem_req, 1'b1);
    check_eq("first_req_addr", bus.mem_addr, 32'h0);
  endtask

  initial begin
    logic          found;
    logic          wp;
    logic [AW-1:0] waddr[$];
    lat_rand = 1'b0;
    lat_fix  = 1;
    spur_en  = 1'b0;

    // In-order stream, response two cycles after grant.
    do_reset();
    repeat (30) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("stream_len", pop_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < pop_log.size()) check_eq("stream_order", pop_log[i], 32'(i));
    end

    // Decoder stalled: queue fills, requests stop; one pop buys one request.
    do_reset();
    repeat (40) cycle(1'b1, 1'b0, 1'b0, '0);
    check_eq("full_grants", grants, 4);
    check_eq("full_count", bus.count, DEPTH);
    check_eq("full_no_req", bus.mem_req, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    repeat (20) cycle(1'b1, 1'b0, 1'b0, '0);
    check_eq("refill_grants", grants, 5);
    check_eq("refill_count", bus.count, DEPTH);

    // Redirect while waiting for address 5.
    do_reset();
    lat_fix = 2;
    found   = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      found = pend && (pend_addr == 32'h5) && (lat > 0);
    end
    check_eq("wait5_reached", found, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h100);
    for (int i = 0; i < 50 && !bus.mem_req; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("redir_req_addr", bus.mem_addr, 32'h100);
    for (int i = 0; i < 50 && !bus.instr_valid; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("redir_first_instr", bus.instr_addr, 32'h100);

    // Redirect coinciding with a response and a pop, two entries queued.
    do_reset();
    lat_fix = 1;
    found   = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      found = (bus.count == 2) && pend && (lat == 0);
    end
    check_eq("rv_redir_reached", found, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h200);
    check_eq("rv_redir_count", bus.count, 0);
    check_eq("rv_redir_valid", bus.instr_valid, 1'b0);
    for (int i = 0; i < 50 && !bus.mem_req; i++) cycle(1'b1, 1'b0, 1'b0, '0);
    check_eq("rv_redir_req_addr", bus.mem_addr, 32'h200);

    // Randomized traffic: stalls, redirects, variable latency, stray responses.
    do_reset();
    lat_rand = 1'b1;
    spur_en  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0,
            (i < 1500) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 4) < 3),
            $urandom_range(0, 31) == 0,
            AW'($urandom()));
    end
    check_eq("rand_progress", pops > 100, 1'b1);
    spur_en = 1'b0;

    // Address wrap from the top of the address space.
    bus_w.mem_gnt     = 1'b1;
    bus_w.instr_ready = 1'b1;
    wp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus_w.mem_rvalid = wp;
      bus_w.mem_rdata  = '0;
      if (bus_w.mem_req) waddr.push_back(bus_w.mem_addr);
      wp = bus_w.mem_req;
      @(posedge clk);
      #1;
    end
    check_eq("wrap_grants", waddr.size() >= 2, 1'b1);
    if (waddr.size() >= 2) begin
      check_eq("wrap_first", waddr[0], 32'hFFFF_FFFF);
      check_eq("wrap_second", waddr[1], 32'h0);
    end

`ifdef FETCH_UNIT_STALL_COUNT_EN
    // Starved decoder: the stall counter saturates.
    do_reset();
    repeat (70000) cycle(1'b0, 1'b1, 1'b0, '0);
    check_eq("stall_saturate", stall_cycles, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
